rc6_key_sched: RTL and testbench
================================

Name: rc6_key_sched

Overview:
- Key-expansion stage that sits directly upstream of the RC6 encrypt/decrypt core.
- Takes a 128-bit user key and runs the RC6-32/20/16 key schedule to produce the 44 round keys S[0..43].
- Serves the round keys to the core as 22 paired 64-bit words through a registered read port, replacing the fixed key ROM.
- One schedule step per clock; fully iterative, single adder/rotator datapath.

Parameters:
- ROUNDS, 20, RC6 round count r; round-key count is 2*ROUNDS+4 = 44, pair count is ROUNDS+2 = 22.
- P32, 32'hB7E15163, magic constant P for w=32.
- Q32, 32'h9E3779B9, magic constant Q for w=32.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset.
- key_valid  input  1  new key offered on key_in.
- key_in  input  128  user key, little-endian words: L[0]=key_in[31:0] .. L[3]=key_in[127:96].
- key_ready  output  1  block idle, will accept key_valid this cycle.
- key_ok  output  1  S[0..43] complete and valid for the currently loaded key.
- rd_addr  input  5  round-key pair address, 0..21.
- rd_data  output  64  {S[2*rd_addr], S[2*rd_addr+1]}; [63:32] is the even key (B/A whitening), [31:0] is the odd key (D/C whitening).

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values: state IDLE, key_ready=1, key_ok=0, rd_data=0, S array all 0, L regs 0, A=B=0, counters 0.
- States:
  - IDLE: key_ready=1. key_valid=1 at an edge (E0) latches L[0..3] from key_in, clears key_ok, sets cnt=0, goes to INIT.
  - INIT: key_ready=0. Each edge writes S[cnt]=P32+cnt*Q32 (running sum, mod 2^32) and increments cnt. The edge with cnt=43 goes to MIX with cnt=0, i=0, j=0, A=B=0. Writes occur at E1..E44.
  - MIX: key_ready=0. Each edge performs one iteration:
    - Anew = rotl(S[i]+A+B, 3)
    - Bnew = rotl(L[j]+Anew+B, (Anew+B)[4:0])
    - S[i]<=Anew, L[j]<=Bnew, A<=Anew, B<=Bnew
    - i<=(i==43)?0:i+1; j<=(j+1) mod 4
  - MIX end: exactly 132 iterations (3*max(44,4)) at E45..E176. The edge with cnt=131 sets key_ok=1 and returns to IDLE. key_ready and key_ok are both high from E176 onward.
- Arithmetic: all sums mod 2^32. Rotate amount uses only the low 5 bits; a rotate amount of 0 is the identity.
- Latency: key_ok rises 176 clocks after the accepting edge.
- Handshake: key_valid is ignored while key_ready=0, with no queueing. A new key accepted in IDLE with key_ok=1 restarts the schedule and drops key_ok at E0.
- Read port:
  - rd_data registered, updated every edge from rd_addr regardless of state.
  - Read and write to the same entry on the same edge returns the old value (read-before-write).
  - rd_addr 22..31 returns 64'h0.
  - Contents during INIT/MIX are intermediate; the consumer must gate on key_ok.
- Reset mid-schedule: aborts immediately, returns to reset values. S is not preserved.
- Downstream contract: encrypt reads pairs 0..21 ascending, decrypt reads 21..0 descending. Pair 0 is pre-whitening, pair 21 is post-whitening.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release -> key_ready=1, key_ok=0, rd_data=0 for rd_addr 0..31.
- INIT values: key_in=0, key_valid pulse at E0, rd_addr=0 sampled after E3 -> rd_data=64'hB7E15163_5618CB1C.
- Latency: same key -> key_ok and key_ready rise exactly at E176. key_valid held high throughout -> no restart before E176.
- Schedule correctness: key_in=0 and key_in=128'h78563412_f0debc9a_67452301_efcdab89 -> all 22 pairs match the software model word for word. End-to-end with the core, zero key and zero plaintext -> ciphertext bytes 8f c3 a5 36 56 b1 f7 78 c1 29 df 4e 98 48 a4 1e.
- Rekey and reset abort:
  - New key accepted with key_ok=1 -> key_ok falls on that edge and rises 176 clocks later with the new schedule.
  - Reset asserted at E100 -> immediate reset values, key_ok stays 0.
- Address bounds: rd_addr=21 gives the {S[42],S[43]} pair; rd_addr=22 and 31 -> 64'h0; rd_data changes exactly one cycle after rd_addr.

Source files
------------

// File: rtl/rc6_key_sched.sv
// rtl/rc6_key_sched.sv - RC6-32/20/16 key schedule with a registered round-key pair read port.
// One INIT or MIX step per clock; a new key restarts the schedule from IDLE only.
module rc6_key_sched #(
  parameter int          ROUNDS = 20,
  parameter logic [31:0] P32    = 32'hB7E15163,
  parameter logic [31:0] Q32    = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         key_ok,
  input  logic [4:0]   rd_addr,
  output logic [63:0]  rd_data
);

  localparam int NKEYS  = 2 * ROUNDS + 4;
  localparam int NPAIRS = ROUNDS + 2;
  localparam int NMIX   = 3 * NKEYS;

  typedef enum logic [1:0] {IDLE, INIT, MIX} state_t;

  state_t      state, state_next;
  logic [31:0] s_mem [NKEYS];
  logic [31:0] l_mem [4];
  logic [31:0] a_reg, b_reg, init_val;
  logic [7:0]  cnt;
  logic [5:0]  i_idx;
  logic [1:0]  j_idx;

  logic [31:0] a_new, ab_sum, b_new;
  logic [5:0]  pair_even, pair_odd;
  logic [63:0] rd_word;
  logic        init_last, mix_last;

  // Rotation by duplicating the word: amount 0 falls out as the identity.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] t;
    t = {x, x} << r;
    return t[63:32];
  endfunction

  assign init_last = (cnt == 8'(NKEYS - 1));
  assign mix_last  = (cnt == 8'(NMIX - 1));

  assign a_new  = rotl(s_mem[i_idx] + a_reg + b_reg, 5'd3);
  assign ab_sum = a_new + b_reg;
  assign b_new  = rotl(l_mem[j_idx] + ab_sum, ab_sum[4:0]);

  assign pair_even = {rd_addr, 1'b0};
  assign pair_odd  = {rd_addr, 1'b1};
  assign rd_word   = (rd_addr < 5'(NPAIRS)) ? {s_mem[pair_even], s_mem[pair_odd]} : 64'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_next = INIT;
      end
      INIT: if (init_last) state_next = MIX;
      MIX:  if (mix_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NKEYS; k++) s_mem[k] <= '0;
      for (int k = 0; k < 4; k++)     l_mem[k] <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      init_val <= '0;
      cnt      <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      key_ok   <= 1'b0;
      rd_data  <= '0;
    end else begin
      // Nonblocking read of s_mem gives read-before-write on a shared entry.
      rd_data <= rd_word;
      case (state)
        IDLE: begin
          if (key_valid) begin
            for (int k = 0; k < 4; k++) l_mem[k] <= key_in[32*k +: 32];
            key_ok   <= 1'b0;
            cnt      <= '0;
            init_val <= P32;
          end
        end
        INIT: begin
          s_mem[cnt[5:0]] <= init_val;
          init_val        <= init_val + Q32;
          if (init_last) begin
            cnt   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            a_reg <= '0;
            b_reg <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MIX: begin
          s_mem[i_idx] <= a_new;
          l_mem[j_idx] <= b_new;
          a_reg        <= a_new;
          b_reg        <= b_new;
          i_idx        <= (i_idx == 6'(NKEYS - 1)) ? 6'd0 : i_idx + 6'd1;
          j_idx        <= j_idx + 2'd1;
          if (mix_last) begin
            cnt    <= '0;
            key_ok <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc6_key_sched.sv
// tb/tb_rc6_key_sched.sv - directed bench for rc6_key_sched with a reference schedule and RC6 encrypt model.
module tb_rc6_key_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready, key_ok;
  logic [4:0]   rd_addr = '0;
  logic [63:0]  rd_data;

  localparam logic [127:0] KEY2 = 128'h78563412_f0debc9a_67452301_efcdab89;
  localparam logic [127:0] CT_ZERO = 128'h1ea48498_4edf29c1_78f7b156_36a5c38f;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] exp;
  } rd_vec_t;

  rd_vec_t     tbl [32];
  logic [31:0] model_s [44];
  logic [31:0] dut_s [44];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n;
  int          ok_seen;
  logic [63:0] prev_exp;

  rc6_key_sched dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .key_ok(key_ok), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] r);
    logic [31:0] y;
    y = x;
    for (int k = 0; k < 32; k++) if (k < int'(r)) y = {y[30:0], y[31]};
    return y;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] l [4];
    logic [31:0] a, b, t;
    int ii, jj;
    for (int w = 0; w < 4; w++) l[w] = k[32*w +: 32];
    model_s[0] = 32'hB7E15163;
    for (int s = 1; s < 44; s++) model_s[s] = model_s[s-1] + 32'h9E3779B9;
    a = 0; b = 0; ii = 0; jj = 0;
    for (int v = 0; v < 132; v++) begin
      a = rol(model_s[ii] + a + b, 5'd3);
      model_s[ii] = a;
      t = a + b;
      b = rol(l[jj] + t, t[4:0]);
      l[jj] = b;
      ii = (ii + 1) % 44;
      jj = (jj + 1) % 4;
    end
  endtask

  // Standard RC6 encryption of an all-zero block with the round keys read from the DUT.
  function automatic logic [127:0] encrypt_zero();
    logic [31:0] a, b, c, d, t, u, tmp;
    a = 0; b = 0; c = 0; d = 0;
    b = b + dut_s[0];
    d = d + dut_s[1];
    for (int r = 1; r <= 20; r++) begin
      t = rol(b * (2 * b + 1), 5'd5);
      u = rol(d * (2 * d + 1), 5'd5);
      a = rol(a ^ t, u[4:0]) + dut_s[2*r];
      c = rol(c ^ u, t[4:0]) + dut_s[2*r+1];
      tmp = a; a = b; b = c; c = d; d = tmp;
    end
    a = a + dut_s[42];
    c = c + dut_s[43];
    return {d, c, b, a};
  endfunction

  task automatic wait_ok(output int edges, input int pulse_at);
    edges = 0;
    while (!key_ok && edges < 400) begin
      tick();
      edges++;
      key_valid = (edges == pulse_at);
    end
    key_valid = 1'b0;
  endtask

  initial begin
    // Reset then idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    chk("reset_key_ready", 64'(key_ready), 64'd1);
    chk("reset_key_ok", 64'(key_ok), 64'd0);
    for (int p = 0; p < 32; p++) begin
      tbl[p].addr = 5'(p);
      tbl[p].exp  = 64'h0;
    end
    for (int p = 0; p < 32; p++) begin
      rd_addr = tbl[p].addr;
      tick();
      chk($sformatf("reset_rd_%0d", p), rd_data, tbl[p].exp);
    end

    // Zero key: INIT value at E3 and exact latency with key_valid held high
    rd_addr   = 5'd0;
    key_in    = '0;
    key_valid = 1'b1;
    tick();
    chk("e0_key_ready", 64'(key_ready), 64'd0);
    chk("e0_key_ok", 64'(key_ok), 64'd0);
    n = 0;
    while (!key_ok && n < 400) begin
      tick();
      n++;
      if (n == 3) chk("init_pair0_e3", rd_data, 64'hB7E15163_5618CB1C);
    end
    key_valid = 1'b0;
    chk("latency_zero_key", 64'(n), 64'd176);
    chk("done_key_ready", 64'(key_ready), 64'd1);

    // Full schedule plus address bounds, checking the one-cycle read latency
    build_model('0);
    for (int p = 0; p < 32; p++) begin
      tbl[p].addr = 5'(p);
      tbl[p].exp  = (p < 22) ? {model_s[2*p], model_s[2*p+1]} : 64'h0;
    end
    prev_exp = tbl[0].exp;
    for (int p = 0; p < 32; p++) begin
      rd_addr = tbl[p].addr;
      #2;
      chk($sformatf("rd_hold_%0d", p), rd_data, prev_exp);
      tick();
      chk($sformatf("zero_key_pair_%0d", p), rd_data, tbl[p].exp);
      if (p < 22) begin
        dut_s[2*p]   = rd_data[63:32];
        dut_s[2*p+1] = rd_data[31:0];
      end
      prev_exp = tbl[p].exp;
    end
    chk("zero_key_ciphertext", encrypt_zero(), CT_ZERO);

    // Rekey while key_ok=1; a key_valid pulse mid-schedule must be ignored
    key_in    = KEY2;
    key_valid = 1'b1;
    tick();
    chk("rekey_key_ok_drop", 64'(key_ok), 64'd0);
    key_valid = 1'b0;
    key_in    = '0;
    wait_ok(n, 50);
    chk("latency_rekey", 64'(n), 64'd176);
    build_model(KEY2);
    for (int p = 0; p < 22; p++) begin
      rd_addr = 5'(p);
      tick();
      chk($sformatf("key2_pair_%0d", p), rd_data, {model_s[2*p], model_s[2*p+1]});
    end
    rd_addr = 5'd21;
    tick();
    chk("key2_pair21_again", rd_data, {model_s[42], model_s[43]});

    // Reset abort at E100
    key_in    = KEY2;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    rd_addr   = 5'd0;
    repeat (99) tick();
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk("abort_key_ready", 64'(key_ready), 64'd1);
    chk("abort_key_ok", 64'(key_ok), 64'd0);
    chk("abort_rd_data", rd_data, 64'h0);
    repeat (2) tick();
    reset = 1'b1;
    ok_seen = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (key_ok) ok_seen++;
    end
    chk("abort_key_ok_stays_low", 64'(ok_seen), 64'd0);
    chk("abort_s_cleared", rd_data, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
